// File: rtl/fp_add_sub.sv
// Parametrised floating-point adder/subtractor with stb/ack handshakes on A, B and Z.
// Optional denormal support is enabled by defining FP_ADD_SUB_DENORM_EN.
module fp_add_sub #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [EXP_W+MAN_W:0]   input_a,
  input  logic                   input_a_stb,
  output logic                   input_a_ack,
  input  logic [EXP_W+MAN_W:0]   input_b,
  input  logic                   input_op,
  input  logic                   input_b_stb,
  output logic                   input_b_ack,
  output logic [EXP_W+MAN_W:0]   output_z,
  output logic                   output_z_stb,
  input  logic                   output_z_ack
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int ML  = MAN_W + 5;
  localparam int E2  = EXP_W + 2;
  localparam int LZW = $clog2(ML) + 1;
  localparam logic signed [E2-1:0] BIAS_E  = E2'(2**(EXP_W-1) - 1);
  localparam logic signed [E2-1:0] E_INF_B = E2'(2**EXP_W - 1);
  localparam logic [ML-1:0] ONES_M = '1;
  localparam logic [W-1:0]  NAN_Z  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
`ifdef FP_ADD_SUB_DENORM_EN
  localparam logic signed [E2-1:0] E_MIN = E2'(2 - 2**(EXP_W-1));
`endif

  typedef enum logic [3:0] {GET_A, GET_B, UNPACK, SPECIAL, ALIGN, ADD, NORM, ROUND, PUT_Z} state_t;
  state_t state, state_nxt;

  logic [W-1:0] a, b, res;
  logic op, a_s, b_s, z_s;
  logic signed [E2-1:0] a_e, b_e, z_e;
  logic [ML-1:0] a_m, b_m, z_m;

  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  assign a_exp  = a[W-2:MAN_W];
  assign b_exp  = b[W-2:MAN_W];
  assign a_frac = a[MAN_W-1:0];
  assign b_frac = b[MAN_W-1:0];

  // Special-case detection
  logic spec_hit;
  logic [W-1:0] spec_z;
  always_comb begin
    spec_hit = 1'b1;
    spec_z   = '0;
    if ((&a_exp && |a_frac) || (&b_exp && |b_frac))
      spec_z = NAN_Z;
    else if (&a_exp && &b_exp && (a_s != b_s))
      spec_z = NAN_Z;
    else if (&a_exp)
      spec_z = {a_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (&b_exp)
      spec_z = {b_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (a_m == '0 && b_m == '0)
      spec_z = {a_s & b_s, {(W-1){1'b0}}};
    else if (a_m == '0)
      spec_z = {b_s, b[W-2:0]};
    else if (b_m == '0)
      spec_z = {a_s, a[W-2:0]};
    else
      spec_hit = 1'b0;
  end

  // Alignment barrel shift with sticky collection
  logic a_big;
  logic [E2-1:0] diff;
  logic [ML-1:0] sh_in, sh_out;
  always_comb begin
    a_big = (a_e >= b_e);
    diff  = a_big ? a_e - b_e : b_e - a_e;
    sh_in = a_big ? b_m : a_m;
    if (diff > E2'(ML - 2))
      sh_out = {{(ML-1){1'b0}}, 1'b1};
    else
      sh_out = (sh_in >> diff) | {{(ML-1){1'b0}}, |(sh_in & ~(ONES_M << diff))};
  end

  // Leading-zero count below the carry bit; the limiter keeps the biased exponent >= 1
  logic [LZW-1:0] lz, nsh;
  always_comb begin
    lz = LZW'(ML - 1);
    for (int unsigned i = 0; i < ML - 1; i++)
      if (z_m[i]) lz = LZW'(ML - 2 - i);
  end
`ifdef FP_ADD_SUB_DENORM_EN
  logic signed [E2-1:0] lim;
  always_comb begin
    lim = z_e - E_MIN;
    nsh = (lim < $signed(E2'(lz))) ? lim[LZW-1:0] : lz;
  end
`else
  assign nsh = lz;
`endif

  // Round to nearest even and pack
  logic rnd_up, hid;
  logic [MAN_W+1:0] rsum;
  logic [MAN_W-1:0] frac;
  logic signed [E2-1:0] biased;
  logic [W-1:0] rnd_z;
  always_comb begin
    rnd_up = z_m[2] & (z_m[1] | z_m[0] | z_m[3]);
    rsum   = {1'b0, z_m[ML-2:3]} + (MAN_W+2)'(rnd_up);
    biased = (rsum[MAN_W+1] ? z_e + E2'(1) : z_e) + BIAS_E;
    frac   = rsum[MAN_W+1] ? rsum[MAN_W:1] : rsum[MAN_W-1:0];
    hid    = rsum[MAN_W+1] | rsum[MAN_W];
    if (biased >= E_INF_B)
      rnd_z = {z_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FP_ADD_SUB_DENORM_EN
    else if (!hid)
      rnd_z = {z_s, {EXP_W{1'b0}}, frac};
`else
    else if (!hid || biased < 1)
      rnd_z = {z_s, {(W-1){1'b0}}};
`endif
    else
      rnd_z = {z_s, biased[EXP_W-1:0], frac};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      GET_A:   if (input_a_ack && input_a_stb) state_nxt = GET_B;
      GET_B:   if (input_b_ack && input_b_stb) state_nxt = UNPACK;
      UNPACK:  state_nxt = SPECIAL;
      SPECIAL: state_nxt = spec_hit ? PUT_Z : ALIGN;
      ALIGN:   state_nxt = ADD;
      ADD:     state_nxt = NORM;
      NORM:    state_nxt = ROUND;
      ROUND:   state_nxt = PUT_Z;
      PUT_Z:   if (output_z_stb && output_z_ack) state_nxt = GET_A;
      default: state_nxt = GET_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= GET_A;
      input_a_ack <= 1'b0; input_b_ack <= 1'b0;
      output_z_stb <= 1'b0; output_z <= '0;
      a <= '0; b <= '0; res <= '0; op <= 1'b0;
      a_s <= 1'b0; b_s <= 1'b0; z_s <= 1'b0;
      a_e <= '0; b_e <= '0; z_e <= '0;
      a_m <= '0; b_m <= '0; z_m <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        GET_A:
          if (input_a_ack && input_a_stb) begin
            a <= input_a; input_a_ack <= 1'b0;
          end else input_a_ack <= 1'b1;
        GET_B:
          if (input_b_ack && input_b_stb) begin
            b <= input_b; op <= input_op; input_b_ack <= 1'b0;
          end else input_b_ack <= 1'b1;
        UNPACK: begin
          a_s <= a[W-1];
          b_s <= b[W-1] ^ op;
          a_m <= {1'b0, |a_exp, a_frac, 3'b000};
          b_m <= {1'b0, |b_exp, b_frac, 3'b000};
          a_e <= $signed({2'b00, a_exp}) - BIAS_E;
          b_e <= $signed({2'b00, b_exp}) - BIAS_E;
`ifdef FP_ADD_SUB_DENORM_EN
          if (a_exp == '0) a_e <= E_MIN;
          if (b_exp == '0) b_e <= E_MIN;
`else
          if (a_exp == '0) a_m <= '0;
          if (b_exp == '0) b_m <= '0;
`endif
        end
        SPECIAL: res <= spec_z;
        ALIGN: begin
          z_e <= a_big ? a_e : b_e;
          if (a_big) b_m <= sh_out;
          else       a_m <= sh_out;
        end
        ADD:
          if (a_s == b_s) begin
            z_m <= a_m + b_m; z_s <= a_s;
          end else if (a_m >= b_m) begin
            z_m <= a_m - b_m; z_s <= (a_m == b_m) ? 1'b0 : a_s;
          end else begin
            z_m <= b_m - a_m; z_s <= b_s;
          end
        NORM:
          if (z_m[ML-1]) begin
            z_m <= {1'b0, z_m[ML-1:2], z_m[1] | z_m[0]};
            z_e <= z_e + E2'(1);
          end else begin
            z_m <= z_m << nsh;
            z_e <= z_e - $signed(E2'(nsh));
          end
        ROUND: res <= rnd_z;
        PUT_Z:
          if (output_z_stb && output_z_ack) output_z_stb <= 1'b0;
          else begin
            output_z_stb <= 1'b1; output_z <= res;
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_sub.sv
// Directed self-checking bench for fp_add_sub (single precision).
module tb_fp_add_sub;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_a = '0, input_b = '0;
  logic        input_a_stb = 1'b0, input_b_stb = 1'b0, input_op = 1'b0;
  logic        input_a_ack, input_b_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  fp_add_sub #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst),
    .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
    .input_b(input_b), .input_op(input_op), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
    .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack)
  );

  always #5 clk = ~clk;

  // Drives one operation and returns the edge count from B transfer to stb rising (999 on handshake timeout)
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                        output int lat, output logic b_early);
    int t;
    b_early = 1'b0;
    @(negedge clk);
    input_a = a; input_b = b; input_op = op;
    input_a_stb = 1'b1; input_b_stb = 1'b1;
    t = 0;
    while (input_a_ack !== 1'b1 && t < 50) begin
      if (input_b_ack !== 1'b0) b_early = 1'b1;
      @(negedge clk); t++;
    end
    if (t >= 50) begin lat = 999; input_a_stb = 1'b0; input_b_stb = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    input_a_stb = 1'b0;
    t = 0;
    while (input_b_ack !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin lat = 999; input_b_stb = 1'b0; return; end
    @(posedge clk);
    #1 input_b_stb = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); lat++; #1;
    end while (output_z_stb !== 1'b1 && lat < 40);
  endtask

  task automatic accept();
    @(negedge clk);
    output_z_ack = 1'b1;
    @(posedge clk);
    #1 output_z_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_checks++; if (input_a_ack !== 1'b0) begin n_fail++; $display("FAIL reset_a_ack got %b want 0", input_a_ack); end
    n_checks++; if (input_b_ack !== 1'b0) begin n_fail++; $display("FAIL reset_b_ack got %b want 0", input_b_ack); end
    n_checks++; if (output_z_stb !== 1'b0) begin n_fail++; $display("FAIL reset_z_stb got %b want 0", output_z_stb); end
    n_checks++; if (output_z !== 32'h0) begin n_fail++; $display("FAIL reset_z got %h want 00000000", output_z); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat; logic be;
    logic [31:0] va [3] = '{32'h3F800000, 32'h40400000, 32'h3F800000};
    logic [31:0] vb [3] = '{32'h40000000, 32'h3F800000, 32'h40000000};
    logic        vo [3] = '{1'b0, 1'b1, 1'b1};
    logic [31:0] vz [3] = '{32'h40400000, 32'h40000000, 32'hBF800000};
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], vo[i], lat, be);
      n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL basic_lat[%0d] got %0d want 7", i, lat); end
      n_checks++; if (output_z !== vz[i]) begin n_fail++; $display("FAIL basic_z[%0d] got %h want %h", i, output_z, vz[i]); end
      n_checks++; if (be !== 1'b0) begin n_fail++; $display("FAIL basic_b_ack_in_get_a[%0d] got %b want 0", i, be); end
      accept();
      n_checks++; if (output_z_stb !== 1'b0) begin n_fail++; $display("FAIL basic_stb_drop[%0d] got %b want 0", i, output_z_stb); end
    end
  endtask

  task automatic test_cancel();
    int lat; logic be;
    run_op(32'h3F800000, 32'h3F800000, 1'b1, lat, be);
    n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL cancel_lat got %0d want 7", lat); end
    n_checks++; if (output_z !== 32'h00000000) begin n_fail++; $display("FAIL cancel_z got %h want 00000000", output_z); end
    accept();
    run_op(32'h80000000, 32'h80000000, 1'b0, lat, be);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL negzero_lat got %0d want 3", lat); end
    n_checks++; if (output_z !== 32'h80000000) begin n_fail++; $display("FAIL negzero_z got %h want 80000000", output_z); end
    accept();
  endtask

  task automatic test_rounding();
    int lat; logic be;
    run_op(32'h3F800000, 32'h33800000, 1'b0, lat, be);
    n_checks++; if (output_z !== 32'h3F800000) begin n_fail++; $display("FAIL round_tie_even got %h want 3F800000", output_z); end
    accept();
    run_op(32'h3F800001, 32'h33800000, 1'b0, lat, be);
    n_checks++; if (output_z !== 32'h3F800002) begin n_fail++; $display("FAIL round_tie_up got %h want 3F800002", output_z); end
    accept();
  endtask

  task automatic test_specials();
    int lat; logic be;
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, lat, be);
    n_checks++; if (output_z !== 32'h7F800000) begin n_fail++; $display("FAIL overflow_z got %h want 7F800000", output_z); end
    accept();
    run_op(32'h7F800000, 32'h7F800000, 1'b1, lat, be);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL inf_sub_lat got %0d want 3", lat); end
    n_checks++; if (output_z !== 32'h7FC00000) begin n_fail++; $display("FAIL inf_sub_z got %h want 7FC00000", output_z); end
    accept();
    run_op(32'h7FC00001, 32'h3F800000, 1'b0, lat, be);
    n_checks++; if (output_z !== 32'h7FC00000) begin n_fail++; $display("FAIL nan_z got %h want 7FC00000", output_z); end
    accept();
  endtask

  task automatic test_denorm();
    int lat; logic be;
    logic [31:0] want_z; int want_lat;
`ifdef FP_ADD_SUB_DENORM_EN
    want_z = 32'h00000002; want_lat = 7;
`else
    want_z = 32'h00000000; want_lat = 3;
`endif
    run_op(32'h00000001, 32'h00000001, 1'b0, lat, be);
    n_checks++; if (lat !== want_lat) begin n_fail++; $display("FAIL denorm_lat got %0d want %0d", lat, want_lat); end
    n_checks++; if (output_z !== want_z) begin n_fail++; $display("FAIL denorm_z got %h want %h", output_z, want_z); end
    accept();
  endtask

  task automatic test_backpressure();
    int lat; logic be; int extra;
    run_op(32'h3F800000, 32'h40000000, 1'b0, lat, be);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (output_z !== 32'h40400000) begin n_fail++; $display("FAIL bp_hold_z[%0d] got %h want 40400000", i, output_z); end
      n_checks++; if (output_z_stb !== 1'b1) begin n_fail++; $display("FAIL bp_hold_stb[%0d] got %b want 1", i, output_z_stb); end
      n_checks++; if (input_a_ack !== 1'b0) begin n_fail++; $display("FAIL bp_a_ack[%0d] got %b want 0", i, input_a_ack); end
    end
    accept();
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (output_z_stb !== 1'b0) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL bp_single_transfer got %0d stb cycles want 0", extra); end
  endtask

  task automatic test_abort();
    int lat, t, pulses; logic be;
    @(negedge clk);
    input_a = 32'h3F800000; input_b = 32'h40000000; input_op = 1'b0;
    input_a_stb = 1'b1;
    t = 0;
    while (input_a_ack !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    @(posedge clk);
    @(negedge clk); input_a_stb = 1'b0; input_b_stb = 1'b1;
    t = 0;
    while (input_b_ack !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    @(posedge clk);
    #1 input_b_stb = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (input_a_ack !== 1'b0) begin n_fail++; $display("FAIL abort_a_ack got %b want 0", input_a_ack); end
    n_checks++; if (input_b_ack !== 1'b0) begin n_fail++; $display("FAIL abort_b_ack got %b want 0", input_b_ack); end
    n_checks++; if (output_z_stb !== 1'b0) begin n_fail++; $display("FAIL abort_stb got %b want 0", output_z_stb); end
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (output_z_stb !== 1'b0) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_no_pulse got %0d stb cycles want 0", pulses); end
    run_op(32'h3F800000, 32'h40000000, 1'b0, lat, be);
    n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL abort_next_lat got %0d want 7", lat); end
    n_checks++; if (output_z !== 32'h40400000) begin n_fail++; $display("FAIL abort_next_z got %h want 40400000", output_z); end
    accept();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cancel();
    test_rounding();
    test_specials();
    test_denorm();
    test_backpressure();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
